// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks a low row, debounces the first low column, emits a one-cycle key event.
// Latency: 2-cycle synchronizer + up to 4 scan ticks + DEBOUNCE_SCANS ticks + 1 cycle; no backpressure, events are fire-and-forget.
module keypad_scanner #(
    parameter int F_CLK          = 50000000,
    parameter int F_SCAN         = 1000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_key_col,
    output logic [3:0] o_key_row,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_key_held
);
    localparam int TICK_DIV = F_CLK / F_SCAN;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_HELD} state_t;

    state_t          r_state, w_state_nxt;
    logic [TW-1:0]   r_tick_cnt;
    logic [3:0]      r_col_s1, r_col_s2;
    logic [1:0]      r_row, w_row_nxt;
    logic [3:0]      r_key_row;
    logic [CW-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]      r_lat_col, w_lat_col_nxt;
    logic [3:0]      r_key_code;
    logic            r_key_valid, r_key_held;
    logic            w_tick, w_any_low, w_lat_low, w_accept, w_release;
    logic [1:0]      w_low_col;

    assign w_tick    = (r_tick_cnt == TICK_LAST);
    assign w_any_low = ~&r_col_s2;
    assign w_lat_low = ~r_col_s2[r_lat_col];
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    // Lowest-index pressed column wins when several keys share the row.
    always_comb begin
        w_low_col = 2'd0;
        if (!r_col_s2[0])      w_low_col = 2'd0;
        else if (!r_col_s2[1]) w_low_col = 2'd1;
        else if (!r_col_s2[2]) w_low_col = 2'd2;
        else if (!r_col_s2[3]) w_low_col = 2'd3;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_cnt_nxt     = r_cnt;
        w_lat_col_nxt = r_lat_col;
        w_accept      = 1'b0;
        w_release     = 1'b0;
        case (r_state)
            S_SCAN: if (w_tick) begin
                if (w_any_low) begin
                    w_lat_col_nxt = w_low_col;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_DEBOUNCE;
                end else begin
                    w_row_nxt = r_row + 2'd1;
                end
            end
            S_DEBOUNCE: if (w_tick) begin
                if (w_lat_low) begin
                    if (w_cnt_inc == CNT_MAX) begin
                        w_accept    = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_HELD;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nxt   = '0;
                    w_row_nxt   = r_row + 2'd1;
                    w_state_nxt = S_SCAN;
                end
            end
            S_HELD: if (w_tick) begin
                // Any bounce back to pressed restarts the release count.
                if (!w_lat_low) begin
                    if (w_cnt_inc == CNT_MAX) begin
                        w_release   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_row_nxt   = r_row + 2'd1;
                        w_state_nxt = S_SCAN;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: w_state_nxt = S_SCAN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_SCAN;
            r_tick_cnt  <= '0;
            r_col_s1    <= 4'hF;
            r_col_s2    <= 4'hF;
            r_row       <= 2'd0;
            r_key_row   <= 4'b1110;
            r_cnt       <= '0;
            r_lat_col   <= 2'd0;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_tick_cnt  <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_col_s1    <= i_key_col;
            r_col_s2    <= r_col_s1;
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_key_row   <= ~(4'b0001 << w_row_nxt);
            r_cnt       <= w_cnt_nxt;
            r_lat_col   <= w_lat_col_nxt;
            r_key_valid <= w_accept;
            if (w_accept) begin
                r_key_code <= {r_row, r_lat_col};
                r_key_held <= 1'b1;
            end else if (w_release) begin
                r_key_held <= 1'b0;
            end
        end
    end

    assign o_key_row   = r_key_row;
    assign o_key_code  = r_key_code;
    assign o_key_valid = r_key_valid;
    assign o_key_held  = r_key_held;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 10-cycle scan tick and 3-scan debounce.
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys = 16'h0;
    logic [3:0]  key_col;
    logic [3:0]  key_row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    int          n_checks = 0;
    int          n_fail = 0;
    int          pulses = 0;
    int          p0;
    bit          ok;

    keypad_scanner #(.F_CLK(1000), .F_SCAN(100), .DEBOUNCE_SCANS(3)) dut (
        .i_clk(clk), .i_rst(rst), .i_key_col(key_col),
        .o_key_row(key_row), .o_key_code(key_code),
        .o_key_valid(key_valid), .o_key_held(key_held)
    );

    always #5 clk = ~clk;

    // Keypad model: key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !key_row[r]) key_col[c] = 1'b0;
    end

    always @(posedge clk) if (key_valid === 1'b1) pulses <= pulses + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_held(input logic val, input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (key_held === val) begin found = 1'b1; break; end
        end
    endtask

    task automatic wait_row(input logic [3:0] val, input int max_cyc, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (key_row === val) begin found = 1'b1; break; end
        end
    endtask

    initial begin
        // 1. reset and free-running row scan
        cyc(3);
        rst = 1'b0;
        check("rst_row", 32'(key_row), 32'hE);
        check("rst_code", 32'(key_code), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_held", 32'(key_held), 32'h0);
        cyc(1);  check("scan_r0", 32'(key_row), 32'hE);
        cyc(9);  check("scan_r1", 32'(key_row), 32'hD);
        cyc(10); check("scan_r2", 32'(key_row), 32'hB);
        cyc(10); check("scan_r3", 32'(key_row), 32'h7);
        cyc(10); check("scan_wrap", 32'(key_row), 32'hE);

        // 2. long press of (2,1)
        p0 = pulses;
        keys = 16'h0200;
        wait_held(1'b1, 300, ok);
        check("k21_rise", 32'(ok), 32'h1);
        check("k21_valid", 32'(key_valid), 32'h1);
        check("k21_code", 32'(key_code), 32'h9);
        check("k21_row", 32'(key_row), 32'hB);
        cyc(1);  check("k21_onecyc", 32'(key_valid), 32'h0);
        cyc(100);
        check("k21_frozen", 32'(key_row), 32'hB);
        check("k21_held", 32'(key_held), 32'h1);
        check("k21_pulses", 32'(pulses - p0), 32'h1);
        keys = 16'h0;
        cyc(19); check("k21_held_early", 32'(key_held), 32'h1);
        wait_held(1'b0, 20, ok);
        check("k21_fall", 32'(ok), 32'h1);
        check("k21_resume", 32'(key_row), 32'h7);

        // 3. (0,2) released one tick after detection
        wait_row(4'hE, 60, ok);
        check("k02_sync", 32'(ok), 32'h1);
        p0 = pulses;
        keys = 16'h0004;
        cyc(20); check("k02_frozen", 32'(key_row), 32'hE);
        cyc(1);  keys = 16'h0;
        cyc(9);  check("k02_advance", 32'(key_row), 32'hD);
        cyc(40);
        check("k02_nopulse", 32'(pulses - p0), 32'h0);
        check("k02_noheld", 32'(key_held), 32'h0);

        // 4. (1,1)+(1,3) together: lowest column wins
        wait_row(4'hD, 60, ok);
        p0 = pulses;
        keys = 16'h00A0;
        wait_held(1'b1, 100, ok);
        check("k11_rise", 32'(ok), 32'h1);
        check("k11_valid", 32'(key_valid), 32'h1);
        check("k11_code", 32'(key_code), 32'h5);
        keys = 16'h0;
        wait_held(1'b0, 60, ok);
        check("k11_fall", 32'(ok), 32'h1);
        check("k11_pulses", 32'(pulses - p0), 32'h1);

        // 5. (3,0) with a 2-tick release glitch while held
        p0 = pulses;
        keys = 16'h1000;
        wait_held(1'b1, 100, ok);
        check("k30_rise", 32'(ok), 32'h1);
        check("k30_code", 32'(key_code), 32'hC);
        keys = 16'h0;
        cyc(21); keys = 16'h1000;
        cyc(40);
        check("k30_glitch_held", 32'(key_held), 32'h1);
        check("k30_pulses", 32'(pulses - p0), 32'h1);
        keys = 16'h0;
        wait_held(1'b0, 40, ok);
        check("k30_fall", 32'(ok), 32'h1);

        // 6. reset in the middle of debouncing (2,2)
        wait_row(4'hB, 60, ok);
        check("k22_sync", 32'(ok), 32'h1);
        p0 = pulses;
        keys = 16'h0400;
        cyc(25); rst = 1'b1;
        cyc(1);
        check("k22_rst_row", 32'(key_row), 32'hE);
        check("k22_rst_held", 32'(key_held), 32'h0);
        check("k22_rst_code", 32'(key_code), 32'h0);
        check("k22_rst_valid", 32'(key_valid), 32'h0);
        rst = 1'b0;
        keys = 16'h0;
        cyc(60);
        check("k22_nopulse", 32'(pulses - p0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
